// File: rtl/game_pkg.sv
// Shared game-flow state encoding for the controller and display/overlay logic.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/game_ctrl_tick_cnt.sv
// 8-bit loadable down-counter: decrements on en & tick, saturates at 0.
module tick_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && tick && cnt != '0)
      cnt <= cnt - 8'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// Flappy Bird game-flow FSM: start/flap/pause/over, flap spacing, death lockout, score/best.
module game_ctrl
  import game_pkg::*;
#(
  parameter int FLAP_GAP  = 4,
  parameter int DEAD_HOLD = 60,
  parameter int SCORE_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key1,
  input  logic               key2,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic               pass,
  output logic [1:0]         state,
  output logic               run,
  output logic               flap,
  output logic               world_clr,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best,
  output logic               new_best
);

  state_t st, nxt;
  logic   flap_nxt, clr_nxt, gap_load, hold_load, score_clr, score_inc;
  logic   gap_zero, hold_zero;
  logic   over_first;

  tick_cnt u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (8'(FLAP_GAP)),
    .en       (st == ST_PLAY),
    .tick     (frame_tick),
    .zero     (gap_zero)
  );

  tick_cnt u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (8'(DEAD_HOLD)),
    .en       (st == ST_OVER),
    .tick     (frame_tick),
    .zero     (hold_zero)
  );

  always_comb begin
    nxt       = st;
    flap_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    gap_load  = 1'b0;
    hold_load = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (key1) begin
          nxt       = ST_PLAY;
          flap_nxt  = 1'b1;
          clr_nxt   = 1'b1;
          gap_load  = 1'b1;
          score_clr = 1'b1;
        end
      end
      ST_PLAY: begin
        score_inc = pass;
        if (hit) begin
          nxt       = ST_OVER;
          hold_load = 1'b1;
        end else if (key2) begin
          nxt = ST_PAUSE;
        end else if (key1 && gap_zero) begin
          // gap_zero is the pre-tick value, so a same-cycle tick cannot open the gap
          flap_nxt = 1'b1;
          gap_load = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (key2) nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (key1 && hold_zero) begin
          nxt     = ST_IDLE;
          clr_nxt = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      run        <= 1'b0;
      flap       <= 1'b0;
      world_clr  <= 1'b0;
      score      <= '0;
      best       <= '0;
      new_best   <= 1'b0;
      over_first <= 1'b0;
    end else begin
      st         <= nxt;
      run        <= (nxt == ST_PLAY);
      flap       <= flap_nxt;
      world_clr  <= clr_nxt;
      over_first <= (st != ST_OVER) && (nxt == ST_OVER);
      if (score_clr)
        score <= '0;
      else if (score_inc && score != '1)
        score <= score + 1'b1;
      // Best is judged on the first OVER cycle, after the final pass has landed in score
      if (over_first) begin
        if (score > best) begin
          best     <= score;
          new_best <= 1'b1;
        end else begin
          new_best <= 1'b0;
        end
      end
      if (nxt != ST_OVER)
        new_best <= 1'b0;
    end
  end

  assign state = st;

endmodule
